// File: rtl/elevator_fsm.sv
// rtl/elevator_fsm.sv - four-floor elevator controller with latched hall/cabin calls
//
// Purpose: latches hall calls (SW[3:0]) and cabin calls (KEY[3:0], active-low)
// into a pending register and runs a direction-preserving FSM that moves the
// car one floor per MOVE_CYCLES clocks and holds the door for DOOR_CYCLES.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   SW[17:0]  in   SW[17] sync active-high reset, SW[3:0] hall calls floors 4..1
//   KEY[3:0]  in   cabin calls, active-low, KEY[0] = floor 1
//   HEX0[6:0] out  active-low {g,f,e,d,c,b,a} current floor digit
//   LEDG[8:0] out  [3:0] floor one-hot, [4] up, [5] down, [6] door, [7] idle, [8] pending
//   LEDR[3:0] out  pending requests, floors 4..1
//
// Option macro: ELEVATOR_INPUT_SYNC_EN adds a 2-flop synchronizer on KEY and
// SW[3:0] ahead of the request latch (reset SW[17] is never synchronized).

module elevator_fsm #(
   parameter int MOVE_CYCLES = 50,
   parameter int DOOR_CYCLES = 100
) (
   input  logic        CLOCK_50,
   input  logic [17:0] SW,
   input  logic [3:0]  KEY,
   output logic [6:0]  HEX0,
   output logic [8:0]  LEDG,
   output logic [3:0]  LEDR
);

   localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_MOVE_UP   = 2'd1;
   localparam logic [1:0] S_MOVE_DOWN = 2'd2;
   localparam logic [1:0] S_DOOR_OPEN = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   wire rst = SW[17];

   logic unused_sw;
   assign unused_sw = ^SW[16:4];

   logic [1:0]    state_q, state_d;
   logic [1:0]    floor_q, floor_d;
   logic          dir_q, dir_d;
   logic [3:0]    pending_q, pending_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    req;
   logic [3:0]    clr;

`ifdef ELEVATOR_INPUT_SYNC_EN
   logic [3:0] key_s1_q, key_s2_q;
   logic [3:0] sw_s1_q, sw_s2_q;

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         key_s1_q <= 4'hF;
         key_s2_q <= 4'hF;
         sw_s1_q  <= 4'h0;
         sw_s2_q  <= 4'h0;
      end else begin
         key_s1_q <= KEY;
         key_s2_q <= key_s1_q;
         sw_s1_q  <= SW[3:0];
         sw_s2_q  <= sw_s1_q;
      end
   end

   assign req = ~key_s2_q | sw_s2_q;
`else
   assign req = ~KEY | SW[3:0];
`endif

   // Bits strictly above / strictly below floor f.
   function automatic logic [3:0] above_mask(input logic [1:0] f);
      return 4'(4'b1110 << f);
   endfunction

   function automatic logic [3:0] below_mask(input logic [1:0] f);
      return 4'((4'b0001 << f) - 4'd1);
   endfunction

   logic [1:0] floor_next;
   logic       req_above, req_below, ahead_after_move;

   always_comb begin
      req_above = |(pending_q & above_mask(floor_q));
      req_below = |(pending_q & below_mask(floor_q));
      // Saturating step; the FSM only moves toward existing requests anyway.
      if (state_q == S_MOVE_UP) begin
         floor_next       = (floor_q == 2'd3) ? 2'd3 : floor_q + 2'd1;
         ahead_after_move = |(pending_q & above_mask(floor_next));
      end else begin
         floor_next       = (floor_q == 2'd0) ? 2'd0 : floor_q - 2'd1;
         ahead_after_move = |(pending_q & below_mask(floor_next));
      end
   end

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      clr     = 4'b0000;
      case (state_q)
         S_IDLE: begin
            if (pending_q[floor_q]) begin
               state_d = S_DOOR_OPEN;
               clr     = 4'(4'b0001 << floor_q);
               cnt_d   = DOOR_LOAD;
            end else if ((dir_q == DIR_UP && req_above) || (dir_q == DIR_DOWN && req_below)) begin
               state_d = (dir_q == DIR_UP) ? S_MOVE_UP : S_MOVE_DOWN;
               cnt_d   = MOVE_LOAD;
            end else if (dir_q == DIR_UP && req_below) begin
               dir_d   = DIR_DOWN;
               state_d = S_MOVE_DOWN;
               cnt_d   = MOVE_LOAD;
            end else if (dir_q == DIR_DOWN && req_above) begin
               dir_d   = DIR_UP;
               state_d = S_MOVE_UP;
               cnt_d   = MOVE_LOAD;
            end
         end
         S_MOVE_UP, S_MOVE_DOWN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               floor_d = floor_next;
               if (pending_q[floor_next]) begin
                  state_d = S_DOOR_OPEN;
                  clr     = 4'(4'b0001 << floor_next);
                  cnt_d   = DOOR_LOAD;
               end else if (ahead_after_move) begin
                  cnt_d = MOVE_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            // Door open: calls for this floor are swallowed and extend the door.
            clr = 4'(4'b0001 << floor_q);
            if (req[floor_q]) begin
               cnt_d = DOOR_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
      pending_d = (pending_q | req) & ~clr;
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q   <= S_IDLE;
         floor_q   <= 2'd0;
         dir_q     <= DIR_UP;
         pending_q <= 4'b0000;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      case (floor_q)
         2'd0:    HEX0 = 7'b1111001;
         2'd1:    HEX0 = 7'b0100100;
         2'd2:    HEX0 = 7'b0110000;
         default: HEX0 = 7'b0011001;
      endcase
   end

   assign LEDG = {|pending_q,
                  state_q == S_IDLE,
                  state_q == S_DOOR_OPEN,
                  state_q == S_MOVE_DOWN,
                  state_q == S_MOVE_UP,
                  4'(4'b0001 << floor_q)};
   assign LEDR = pending_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// tb/tb_elevator_fsm.sv - directed self-checking bench for elevator_fsm

module tb_elevator_fsm;

   logic        CLOCK_50 = 1'b0;
   logic [17:0] SW  = 18'd0;
   logic [3:0]  KEY = 4'hF;
   logic [6:0]  HEX0;
   logic [8:0]  LEDG;
   logic [3:0]  LEDR;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;

   elevator_fsm dut (
      .CLOCK_50(CLOCK_50),
      .SW(SW),
      .KEY(KEY),
      .HEX0(HEX0),
      .LEDG(LEDG),
      .LEDR(LEDR)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Counts consecutive cycles LEDG[idx] stays high, bounded.
   task automatic count_while(input int idx, output int n);
      n = 0;
      while (LEDG[idx] && n < 2000) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      SW[17] = 1'b1;
      repeat (5) tick();
      SW[17] = 1'b0;
      checks++;
      if (HEX0 !== D1) begin failures++; $display("FAIL reset_hex got=%b exp=%b", HEX0, D1); end
      checks++;
      if (LEDG !== 9'b010000001) begin failures++; $display("FAIL reset_ledg got=%b exp=%b", LEDG, 9'b010000001); end
      checks++;
      if (LEDR !== 4'b0000) begin failures++; $display("FAIL reset_ledr got=%b exp=%b", LEDR, 4'b0000); end
   endtask

   task automatic test_up_two();
      int n;
      SW[2] = 1'b1;
      tick();
      SW[2] = 1'b0;
      checks++;
      if (LEDR !== 4'b0100) begin failures++; $display("FAIL up2_latch got=%b exp=%b", LEDR, 4'b0100); end
      checks++;
      if (LEDG[8] !== 1'b1) begin failures++; $display("FAIL up2_pend_led got=%b exp=1", LEDG[8]); end
      tick();
      count_while(4, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL up2_move_cycles got=%0d exp=100", n); end
      checks++;
      if (HEX0 !== D3) begin failures++; $display("FAIL up2_hex got=%b exp=%b", HEX0, D3); end
      count_while(6, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL up2_door_cycles got=%0d exp=100", n); end
      checks++;
      if (LEDG !== 9'b010000100) begin failures++; $display("FAIL up2_idle got=%b exp=%b", LEDG, 9'b010000100); end
      checks++;
      if (LEDR !== 4'b0000) begin failures++; $display("FAIL up2_ledr got=%b exp=0000", LEDR); end
   endtask

   task automatic test_up_one();
      int n;
      KEY[3] = 1'b0;
      tick();
      KEY[3] = 1'b1;
      tick();
      count_while(4, n);
      checks++;
      if (n !== 50) begin failures++; $display("FAIL up1_move_cycles got=%0d exp=50", n); end
      checks++;
      if (HEX0 !== D4) begin failures++; $display("FAIL up1_hex got=%b exp=%b", HEX0, D4); end
      count_while(6, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL up1_door_cycles got=%0d exp=100", n); end
      checks++;
      if (LEDG !== 9'b010001000) begin failures++; $display("FAIL up1_idle got=%b exp=%b", LEDG, 9'b010001000); end
   endtask

   task automatic test_same_floor();
      int n;
      KEY[3] = 1'b0;
      tick();
      KEY[3] = 1'b1;
      checks++;
      if (LEDR !== 4'b1000) begin failures++; $display("FAIL same_latch got=%b exp=1000", LEDR); end
      tick();
      checks++;
      if (LEDG !== 9'b001001000) begin failures++; $display("FAIL same_door_ledg got=%b exp=%b", LEDG, 9'b001001000); end
      count_while(6, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL same_door_cycles got=%0d exp=100", n); end
      checks++;
      if (HEX0 !== D4) begin failures++; $display("FAIL same_hex got=%b exp=%b", HEX0, D4); end
   endtask

   task automatic test_down_skip();
      int n;
      SW[1] = 1'b1;
      tick();
      SW[1] = 1'b0;
      tick();
      checks++;
      if (LEDG[5] !== 1'b1) begin failures++; $display("FAIL down_dir got=%b exp=1", LEDG[5]); end
      count_while(5, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL down_move_cycles got=%0d exp=100", n); end
      checks++;
      if (HEX0 !== D2) begin failures++; $display("FAIL down_hex got=%b exp=%b", HEX0, D2); end
      checks++;
      if (LEDG[6] !== 1'b1) begin failures++; $display("FAIL down_door got=%b exp=1", LEDG[6]); end
      count_while(6, n);
      checks++;
      if (LEDG !== 9'b010000010) begin failures++; $display("FAIL down_idle got=%b exp=%b", LEDG, 9'b010000010); end
   endtask

   task automatic test_door_restart();
      int n;
      SW[1] = 1'b1;
      tick();
      SW[1] = 1'b0;
      tick();
      repeat (30) tick();
      KEY[1] = 1'b0;
      tick();
      KEY[1] = 1'b1;
      checks++;
      if (LEDR !== 4'b0000) begin failures++; $display("FAIL restart_not_latched got=%b exp=0000", LEDR); end
      count_while(6, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL restart_door_cycles got=%0d exp=100", n); end
   endtask

   task automatic test_reverse();
      int n;
      SW[0] = 1'b1;
      tick();
      SW[0] = 1'b0;
      tick();
      count_while(5, n);
      count_while(6, n);
      checks++;
      if (LEDG !== 9'b010000001) begin failures++; $display("FAIL rev_start got=%b exp=%b", LEDG, 9'b010000001); end
      KEY[3] = 1'b0;
      tick();
      KEY[3] = 1'b1;
      tick();
      repeat (5) tick();
      SW[0] = 1'b1;
      tick();
      SW[0] = 1'b0;
      checks++;
      if (LEDR !== 4'b1001) begin failures++; $display("FAIL rev_pending got=%b exp=1001", LEDR); end
      count_while(4, n);
      checks++;
      if (n !== 144) begin failures++; $display("FAIL rev_up_cycles got=%0d exp=144", n); end
      checks++;
      if (HEX0 !== D4) begin failures++; $display("FAIL rev_first_stop got=%b exp=%b", HEX0, D4); end
      count_while(6, n);
      checks++;
      if (n !== 100) begin failures++; $display("FAIL rev_door4_cycles got=%0d exp=100", n); end
      tick();
      count_while(5, n);
      checks++;
      if (n !== 150) begin failures++; $display("FAIL rev_down_cycles got=%0d exp=150", n); end
      checks++;
      if (HEX0 !== D1) begin failures++; $display("FAIL rev_second_stop got=%b exp=%b", HEX0, D1); end
      count_while(6, n);
   endtask

   task automatic test_reset_mid_move();
      SW[3] = 1'b1;
      tick();
      SW[3] = 1'b0;
      repeat (20) tick();
      checks++;
      if (LEDG[4] !== 1'b1) begin failures++; $display("FAIL midrst_moving got=%b exp=1", LEDG[4]); end
      SW[17] = 1'b1;
      tick();
      checks++;
      if (LEDG !== 9'b010000001) begin failures++; $display("FAIL midrst_ledg got=%b exp=%b", LEDG, 9'b010000001); end
      checks++;
      if (LEDR !== 4'b0000) begin failures++; $display("FAIL midrst_ledr got=%b exp=0000", LEDR); end
      checks++;
      if (HEX0 !== D1) begin failures++; $display("FAIL midrst_hex got=%b exp=%b", HEX0, D1); end
      SW[17] = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_up_two();
      test_up_one();
      test_same_floor();
      test_down_skip();
      test_door_restart();
      test_reverse();
      test_reset_mid_move();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
